// File: rtl/shift8_ctrl_pkg.sv
// Shared types and default sizing for the shifter8 command sequencer.
// Widths here are defaults only; the top module exposes them as parameters.
package shift8_ctrl_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_MAX_SHIFT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/shift8_ctrl.sv
// Command sequencer for shifter8: loads a word, counts N shifts, captures the
// shifted result and returns it over a valid/ready handshake.
module shift8_ctrl
  import shift8_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [DATA_W-1:0] sh_din,
  output logic              sh_load,
  output logic              sh_LR,
  input  logic [DATA_W-1:0] sh_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // NOTE: cmd_ready is decoded from state, not registered, so it reads 1 during reset.
  assign cmd_ready = (state == IDLE);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_din    <= '0;
      sh_load   <= 1'b0;
      sh_LR     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sh_din  <= cmd_data;
            sh_LR   <= cmd_dir;
            cnt     <= (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
            sh_load <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sh_load <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // shifter8's dout already reflects cnt shifts when cnt reaches zero
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_data  <= sh_dout;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift8_ctrl.sv
// Directed bench for shift8_ctrl with a behavioural shifter8 model
// (LR=1 shifts left, LR=0 shifts right, zero fill).
module tb_shift8_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic [7:0] sh_din;
  logic       sh_load;
  logic       sh_LR;
  logic [7:0] sh_dout = 8'h00;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  int  n_checks = 0;
  int  n_fail   = 0;
  time accept_t;

  always #5 clk = ~clk;

  shift8_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .sh_din    (sh_din),
    .sh_load   (sh_load),
    .sh_LR     (sh_LR),
    .sh_dout   (sh_dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always @(posedge clk) begin
    if (sh_load)    sh_dout <= sh_din;
    else if (sh_LR) sh_dout <= {sh_dout[6:0], 1'b0};
    else            sh_dout <= {1'b0, sh_dout[7:1]};
  end

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [3:0] count;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, " sh_din"},    32'(sh_din),    32'd0);
    check({tag, " sh_load"},   32'(sh_load),   32'd0);
    check({tag, " sh_LR"},     32'(sh_LR),     32'd0);
    check({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check({tag, " res_data"},  32'(res_data),  32'd0);
  endtask

  // Issues one command, measures latency from accept edge to res_valid,
  // optionally stalls the result for 'hold' cycles, then completes the handshake.
  task automatic do_cmd(input string tag, input logic [7:0] d, input logic dir,
                        input logic [3:0] n, input int hold,
                        output logic [7:0] res, output int lat);
    int         loads;
    int         lr_bad;
    int         waited;
    logic [7:0] held;
    loads  = 0;
    lr_bad = 0;
    lat    = 0;
    res_ready = (hold == 0);
    @(negedge clk);
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = n;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " cmd_ready before accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    accept_t = $time;
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    cmd_dir   = ~dir;
    cmd_count = 4'hF;
    if (sh_load) loads++;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (sh_load) loads++;
      if (!res_valid && sh_LR !== dir) lr_bad++;
    end
    check({tag, " res_valid rose"},  32'(res_valid), 32'd1);
    check({tag, " sh_load cycles"},  32'(loads),     32'd1);
    check({tag, " sh_LR stable"},    32'(lr_bad),    32'd0);
    res  = res_data;
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      check({tag, " stall res_valid"}, 32'(res_valid), 32'd1);
      check({tag, " stall res_data"},  32'(res_data),  32'(held));
      check({tag, " stall cmd_ready"}, 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " res_valid after handshake"}, 32'(res_valid), 32'd0);
    check({tag, " idle after handshake"},      32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] res;
    int         lat;
    int         seen;
    time        t_first;

    vecs[0] = '{8'hB5, 1'b1, 4'd3,  8'hA8, 5};
    vecs[1] = '{8'hB5, 1'b0, 4'd2,  8'h2D, 4};
    vecs[2] = '{8'hB5, 1'b0, 4'd0,  8'hB5, 2};
    vecs[3] = '{8'hFF, 1'b1, 4'd12, 8'h00, 10};
    vecs[4] = '{8'hC3, 1'b0, 4'd4,  8'h0C, 6};
    vecs[5] = '{8'hA5, 1'b1, 4'd15, 8'h00, 10};
    vecs[6] = '{8'h3C, 1'b0, 4'd8,  8'h00, 10};
    vecs[7] = '{8'h01, 1'b1, 4'd7,  8'h80, 9};
    vecs[8] = '{8'h80, 1'b0, 4'd7,  8'h01, 9};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_dir   = 1'b0;
    cmd_count = 4'd0;
    res_ready = 1'b1;

    #2;
    check_reset_outputs("reset");

    // commands offered during reset must be ignored
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    cmd_dir   = 1'b1;
    cmd_count = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("cmd during reset");
    @(negedge clk);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset sh_load", 32'(sh_load), 32'd0);

    t_first = 0;
    for (int i = 0; i < 9; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].data, vecs[i].dir, vecs[i].count, 0, res, lat);
      check($sformatf("vec%0d res_data", i), 32'(res), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d latency", i),  32'(lat), 32'(vecs[i].exp_lat));
      if (i == 7) t_first = accept_t;
    end
    check("back-to-back accept spacing", 32'((accept_t - t_first) / 10), 32'd11);

    do_cmd("stall", 8'h81, 1'b0, 4'd1, 4, res, lat);
    check("stall res_data", 32'(res), 32'h40);
    check("stall latency",  32'(lat), 32'd3);

    // reset pulse while SHIFT is counting down
    @(negedge clk);
    cmd_data  = 8'h3C;
    cmd_dir   = 1'b1;
    cmd_count = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("midop accepted", 32'(sh_load), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midop reset");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
    check("midop no res_valid", 32'(seen), 32'd0);

    do_cmd("after reset", 8'h3C, 1'b1, 4'd2, 0, res, lat);
    check("after reset res_data", 32'(res), 32'hF0);
    check("after reset latency",  32'(lat), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
